// File: rtl/bmu_count_ctrl_if.sv
// Op request / writeback handshake bundle for bmu_count_ctrl.
// master = requester side, slave = the count controller.
interface bmu_count_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [XLEN-1:0]   in_rs1;
  logic [RIDX_W-1:0] in_rd_idx;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic [RIDX_W-1:0] out_rd_idx;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_rs1, in_rd_idx,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_rd_idx, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rd_idx,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_rd_idx, out_err
  );
endinterface

// File: rtl/bmu_count_ctrl.sv
// CLZ/CTZ/PCNT sequencer around a combinational CLZ unit.
// BMU_PCNT_FAST_EN: single-cycle PCNT in EXEC instead of 4 beats.
module bmu_count_ctrl #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  bmu_count_ctrl_if.slave bus,
  output logic [XLEN-1:0] clz_rs1,
  input  logic [XLEN-1:0] clz_rd,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_PCNT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLZ  = 2'b00;
  localparam logic [1:0] OP_CTZ  = 2'b01;
  localparam logic [1:0] OP_PCNT = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t            state;
  state_t            start_st;
  logic [XLEN-1:0]   op_q;
  logic [XLEN-1:0]   rev_q;
  logic [RIDX_W-1:0] idx_q;
  logic [1:0]        op_sel;
  logic              vld_q;
  logic              err_q;
  logic [5:0]        data_q;
  logic [RIDX_W-1:0] rd_q;
  logic              accept;
  logic [5:0]        exec_res;
  logic              unused_clz;

  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

`ifdef BMU_PCNT_FAST_EN
  logic [5:0] pop_all;

  always_comb begin
    pop_all = '0;
    for (int i = 0; i < XLEN / 8; i++)
      pop_all = pop_all + {2'b00, pop8(op_q[8*i +: 8])};
  end

  assign start_st = S_EXEC;
`else
  logic [5:0] acc;
  logic [1:0] beat;
  logic [5:0] acc_nxt;

  assign acc_nxt  = acc + {2'b00, pop8(op_q[{beat, 3'b000} +: 8])};
  assign start_st = (bus.in_op == OP_PCNT) ? S_PCNT : S_EXEC;
`endif

  assign unused_clz = ^clz_rd[XLEN-1:5];

  always_comb begin
    rev_q = '0;
    for (int i = 0; i < XLEN; i++) rev_q[XLEN-1-i] = op_q[i];
  end

  assign bus.in_ready = rst_n &
    ((state == S_IDLE) | ((state == S_DONE) & bus.out_ready));
  assign accept = bus.in_valid & bus.in_ready;
  assign busy   = rst_n & (state != S_IDLE);

  always_comb begin
    clz_rs1 = '0;
    unique case (1'b1)
      (rst_n && state == S_EXEC && op_sel == OP_CLZ): clz_rs1 = op_q;
      (rst_n && state == S_EXEC && op_sel == OP_CTZ): clz_rs1 = rev_q;
      default: clz_rs1 = '0;
    endcase
  end

  // The counter is undefined for a zero operand, so that case bypasses it.
  always_comb begin
    exec_res = '0;
    unique case (1'b1)
      (op_sel == OP_RSV): exec_res = '0;
      ((op_sel == OP_CLZ || op_sel == OP_CTZ) && op_q == '0):
        exec_res = 6'd32;
`ifdef BMU_PCNT_FAST_EN
      (op_sel == OP_PCNT): exec_res = pop_all;
`endif
      default: exec_res = {1'b0, clz_rd[4:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= '0;
      idx_q  <= '0;
      op_sel <= OP_CLZ;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
      rd_q   <= '0;
`ifndef BMU_PCNT_FAST_EN
      acc    <= '0;
      beat   <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && bus.out_ready) begin
            vld_q <= 1'b0;
            state <= S_IDLE;
          end
          if (accept) begin
            op_q   <= bus.in_rs1;
            idx_q  <= bus.in_rd_idx;
            op_sel <= bus.in_op;
            state  <= start_st;
`ifndef BMU_PCNT_FAST_EN
            acc    <= '0;
            beat   <= '0;
`endif
          end
        end
        S_EXEC: begin
          vld_q  <= 1'b1;
          data_q <= exec_res;
          rd_q   <= idx_q;
          err_q  <= (op_sel == OP_RSV);
          state  <= S_DONE;
        end
        S_PCNT: begin
`ifdef BMU_PCNT_FAST_EN
          state <= S_IDLE;
`else
          acc  <= acc_nxt;
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            vld_q  <= 1'b1;
            data_q <= acc_nxt;
            rd_q   <= idx_q;
            err_q  <= 1'b0;
            state  <= S_DONE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.out_data   = {{(XLEN-6){1'b0}}, data_q};
  assign bus.out_rd_idx = rd_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_bmu_count_ctrl.sv
// Directed + random bench for bmu_count_ctrl.
// Reference: plain bit-counting functions; TB also models the CLZ unit.
module tb_bmu_count_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] clz_rs1;
  logic [31:0] clz_rd;
  logic        busy;
  logic        force_ones = 1'b0;
  int          checks = 0;
  int          errors = 0;

`ifdef BMU_PCNT_FAST_EN
  localparam int PCNT_LAT = 2;
`else
  localparam int PCNT_LAT = 5;
`endif

  bmu_count_ctrl_if bif ();

  bmu_count_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif),
    .clz_rs1 (clz_rs1),
    .clz_rd  (clz_rd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_clz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int ref_ctz(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 32;
  endfunction

  function automatic logic [31:0] ref_result(
    input logic [1:0] op, input logic [31:0] v);
    case (op)
      2'b00:   return 32'(ref_clz(v));
      2'b01:   return 32'(ref_ctz(v));
      2'b10:   return 32'($countones(v));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_clz_in(
    input logic [1:0] op, input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    if (op == 2'b00) return v;
    if (op == 2'b01) return r;
    return 32'd0;
  endfunction

  // Behavioural CLZ unit; low 5 bits only are meaningful to the DUT.
  always_comb clz_rd = force_ones ? 32'hFFFF_FFFF : 32'(ref_clz(clz_rs1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bif.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] rs1,
                        input logic [4:0] rd,
                        input int stall);
    int lat;
    logic [31:0] exp_d;
    exp_d = ref_result(op, rs1);
    bif.out_ready = (stall == 0);
    bif.in_valid  = 1'b1;
    bif.in_op     = op;
    bif.in_rs1    = rs1;
    bif.in_rd_idx = rd;
    #1;
    chk("in_ready_idle", 32'(bif.in_ready), 32'd1);
    tick();
    bif.in_valid = 1'b0;
    bif.in_rs1   = $urandom;
    chk("clz_rs1", clz_rs1, ref_clz_in(op, rs1));
    chk("busy_run", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("latency", 32'(lat), (op == 2'b10) ? 32'(PCNT_LAT) : 32'd2);
    for (int s = 0; s < stall; s++) begin
      chk("hold_valid", 32'(bif.out_valid), 32'd1);
      chk("hold_data", bif.out_data, exp_d);
      chk("hold_ready", 32'(bif.in_ready), 32'd0);
      tick();
    end
    bif.out_ready = 1'b1;
    chk("out_data", bif.out_data, exp_d);
    chk("out_rd_idx", 32'(bif.out_rd_idx), 32'(rd));
    chk("out_err", 32'(bif.out_err), 32'(op == 2'b11));
    tick();
    chk("valid_drop", 32'(bif.out_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    logic [1:0]  op;
    logic [31:0] v;
    bif.in_valid  = 1'b1;
    bif.in_op     = 2'b00;
    bif.in_rs1    = 32'h0000_1234;
    bif.in_rd_idx = 5'd1;
    bif.out_ready = 1'b1;

    // Reset held two cycles with a pending request.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_in_ready", 32'(bif.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
      chk("rst_out_data", bif.out_data, 32'd0);
      chk("rst_clz_rs1", clz_rs1, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    bif.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bif.in_ready), 32'd1);

    run_op(2'b00, 32'h0001_0000, 5'd7, 0);
    chk("clz_const", 32'(ref_clz(32'h0001_0000)), 32'd15);
    run_op(2'b01, 32'h0000_0080, 5'd9, 0);

    force_ones = 1'b1;
    run_op(2'b00, 32'h0, 5'd2, 0);
    run_op(2'b01, 32'h0, 5'd3, 0);
    force_ones = 1'b0;

    run_op(2'b10, 32'hF0F0_00FF, 5'd4, 0);
    run_op(2'b10, 32'h0, 5'd5, 1);
    run_op(2'b10, 32'hFFFF_FFFF, 5'd6, 0);

    // Backpressure then back-to-back transfer + accept.
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_op     = 2'b00;
    bif.in_rs1    = 32'h0001_0000;
    bif.in_rd_idx = 5'd7;
    tick();
    bif.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bif.out_valid), 32'd1);
      chk("bp_data", bif.out_data, 32'd15);
      chk("bp_idx", 32'(bif.out_rd_idx), 32'd7);
      chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
      tick();
    end
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    bif.in_op     = 2'b10;
    bif.in_rs1    = 32'hF0F0_00FF;
    bif.in_rd_idx = 5'd3;
    #1;
    chk("b2b_in_ready", 32'(bif.in_ready), 32'd1);
    tick();
    bif.in_valid = 1'b0;
    chk("b2b_valid_low", 32'(bif.out_valid), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    chk("b2b_latency", 32'(lat), 32'(PCNT_LAT));
    chk("b2b_data", bif.out_data, 32'd16);
    chk("b2b_idx", 32'(bif.out_rd_idx), 32'd3);
    tick();
    chk("b2b_drop", 32'(bif.out_valid), 32'd0);

    run_op(2'b11, 32'hDEAD_BEEF, 5'd11, 0);

    // Reset in the middle of an iterative PCNT.
    bif.in_valid  = 1'b1;
    bif.in_op     = 2'b10;
    bif.in_rs1    = 32'h0F0F_0F0F;
    bif.in_rd_idx = 5'd12;
    tick();
    bif.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      tick();
    end
    chk("mid_rst_ready", 32'(bif.in_ready), 32'd1);

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       v = 32'h0;
        1:       v = 32'h1 << $urandom_range(0, 31);
        2:       v = $urandom;
        default: v = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(op, v, 5'($urandom), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
